seq_detect_param: RTL



---
 rtl/seq_detect_param.sv | 78 +++++++
 1 files changed

// File: rtl/seq_detect_param.sv
// seq_detect_param: serial pattern detector with a runtime-loadable pattern, length and overlap mode,
// an input-valid qualifier, a registered match pulse and a saturating match counter.
module seq_detect_param #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8,
    localparam int LEN_W = $clog2(PAT_W + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             x,
    input  logic             in_valid,
    input  logic             cfg_load,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             cfg_overlap,
    input  logic             cnt_clr,
    output logic             z,
    output logic [CNT_W-1:0] match_count,
    output logic [LEN_W-1:0] fill
);
    localparam int RST_LEN = (PAT_W < 4) ? PAT_W : 4;
    localparam logic [LEN_W-1:0] FULL = LEN_W'(PAT_W);

    logic [PAT_W-1:0] r_hist, r_pat;
    logic [LEN_W-1:0] r_fill, r_len;
    logic             r_ovl, r_z;
    logic [CNT_W-1:0] r_cnt;

    logic [PAT_W-1:0] w_hist_n, w_mask;
    logic [LEN_W-1:0] w_fill_n, w_len_c;
    logic             w_match;

    always_comb begin
        w_hist_n = {r_hist[PAT_W-2:0], x};
        w_fill_n = (r_fill == FULL) ? r_fill : r_fill + 1'b1;
        w_len_c  = (cfg_len == '0 || cfg_len > FULL) ? FULL : cfg_len;
        w_mask   = '0;
        for (int i = 0; i < PAT_W; i++) w_mask[i] = (i < int'(r_len));
        // only the newest len bits of the history take part in the compare
        w_match  = in_valid && !cfg_load && (w_fill_n >= r_len)
                   && (((w_hist_n ^ r_pat) & w_mask) == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hist <= '0;
            r_fill <= '0;
            r_z    <= 1'b0;
            r_cnt  <= '0;
            r_pat  <= PAT_W'(4'b1101);
            r_len  <= LEN_W'(RST_LEN);
            r_ovl  <= 1'b1;
        end else begin
            if (cnt_clr)
                r_cnt <= '0;
            else if (w_match && !(&r_cnt))
                r_cnt <= r_cnt + 1'b1;
            if (cfg_load) begin
                r_pat  <= cfg_pattern;
                r_len  <= w_len_c;
                r_ovl  <= cfg_overlap;
                r_hist <= '0;
                r_fill <= '0;
                r_z    <= 1'b0;
            end else if (in_valid) begin
                r_hist <= w_hist_n;
                r_fill <= (w_match && !r_ovl) ? '0 : w_fill_n;
                r_z    <= w_match;
            end else begin
                r_z    <= 1'b0;
            end
        end
    end

    assign z           = r_z;
    assign match_count = r_cnt;
    assign fill        = r_fill;
endmodule
